// File: rtl/led_color_arbiter.sv
// Shares the RGB LED between the background pattern and two prioritised requesters (bit 0 wins).
// All outputs registered, one cycle from req/colour sampling; no backpressure, requesters simply hold req.
module led_color_arbiter #(
  parameter int unsigned HOLD_TICKS = 100_000,
  parameter int unsigned MAX_TICKS  = 50_000_000,
  parameter int unsigned GAP_TICKS  = 25_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] bg_red,
  input  logic [14:0] bg_green,
  input  logic [14:0] bg_blue,
  input  logic [1:0]  req,
  input  logic [44:0] rgb0,
  input  logic [44:0] rgb1,
  output logic [1:0]  grant,
  output logic [14:0] red,
  output logic [14:0] green,
  output logic [14:0] blue,
  output logic        bg_restart
);

  typedef enum logic [1:0] {
    S_BG    = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_TICKS - 1);
  localparam logic [31:0] MAX_LAST  = 32'(MAX_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_TICKS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic        r_owner;
  logic        w_owner_nxt;
  logic [1:0]  r_lock;
  logic [1:0]  w_lock_set;
  logic [1:0]  w_elig;
  logic        w_winner;
  logic        w_hold_done;
  logic        w_max_done;
  logic        w_gap_done;
  logic        w_illegal;
  logic [44:0] r_own_rgb;
  logic [44:0] w_own_rgb_nxt;
  logic [44:0] w_rgb_sel;
  logic [44:0] w_col_nxt;
  logic [1:0]  w_grant_nxt;
  logic        w_restart_nxt;

  assign w_elig      = req & ~r_lock;
  assign w_winner    = ~w_elig[0];
  assign w_hold_done = (r_cnt >= HOLD_LAST);
  assign w_max_done  = (r_cnt >= MAX_LAST);
  assign w_gap_done  = (r_cnt >= GAP_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_lock_set    = 2'b00;
    w_restart_nxt = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      S_BG: begin
        if (|w_elig) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_winner;
        end
      end
      S_GRANT: begin
        // Timeout outranks release/preemption so the lock is always recorded.
        if (w_max_done) begin
          w_state_nxt         = S_GAP;
          w_lock_set[r_owner] = 1'b1;
        end else if (w_hold_done && (!req[r_owner] || (r_owner && w_elig[0]))) begin
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          if (|w_elig) begin
            w_state_nxt = S_GRANT;
            w_owner_nxt = w_winner;
          end else begin
            w_state_nxt   = S_BG;
            w_restart_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_BG;
        w_illegal   = 1'b1;
      end
    endcase
  end

  // Owner colour tracks rgbN while its request is up, freezes once it drops.
  always_comb begin
    w_rgb_sel     = w_owner_nxt ? rgb1 : rgb0;
    w_own_rgb_nxt = req[w_owner_nxt] ? w_rgb_sel : r_own_rgb;
    w_col_nxt     = 45'd0;
    w_grant_nxt   = 2'b00;
    case (w_state_nxt)
      S_BG:    w_col_nxt = {bg_red, bg_green, bg_blue};
      S_GRANT: begin
        w_col_nxt   = w_own_rgb_nxt;
        w_grant_nxt = w_owner_nxt ? 2'b10 : 2'b01;
      end
      default: w_col_nxt = 45'd0;
    endcase
    if (w_illegal) begin
      w_col_nxt = 45'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BG;
      r_cnt      <= 32'd0;
      r_owner    <= 1'b0;
      r_lock     <= 2'b00;
      r_own_rgb  <= 45'd0;
      grant      <= 2'b00;
      red        <= 15'd0;
      green      <= 15'd0;
      blue       <= 15'd0;
      bg_restart <= 1'b0;
    end else begin
      r_state              <= w_state_nxt;
      r_cnt                <= (w_state_nxt != r_state) ? 32'd0 : r_cnt + 32'd1;
      r_owner              <= w_owner_nxt;
      r_lock               <= req & (r_lock | w_lock_set);
      r_own_rgb            <= w_own_rgb_nxt;
      grant                <= w_grant_nxt;
      {red, green, blue}   <= w_col_nxt;
      bg_restart           <= w_restart_nxt;
    end
  end

endmodule

// File: tb/tb_led_color_arbiter.sv
// Bench for led_color_arbiter: directed scenarios with literal expectations plus random traffic vs a phase/age model.
module tb_led_color_arbiter;

  localparam int HOLD = 4;
  localparam int MAX  = 20;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] bg_red, bg_green, bg_blue;
  logic [1:0]  req;
  logic [44:0] rgb0, rgb1;
  logic [1:0]  grant;
  logic [14:0] red, green, blue;
  logic        bg_restart;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_on  = 1'b0;

  led_color_arbiter #(
    .HOLD_TICKS(HOLD),
    .MAX_TICKS (MAX),
    .GAP_TICKS (GAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bg_red    (bg_red),
    .bg_green  (bg_green),
    .bg_blue   (bg_blue),
    .req       (req),
    .rgb0      (rgb0),
    .rgb1      (rgb1),
    .grant     (grant),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .bg_restart(bg_restart)
  );

  always #5 clk = ~clk;

  // Model: phase 0 = background, 1 = owned, 2 = gap; m_age = which cycle of the phase is ending.
  int          m_phase, m_owner, m_age;
  logic [1:0]  m_lock, m_elig;
  logic [44:0] m_col;
  bit          m_timeout;
  logic [1:0]  e_grant;
  logic [44:0] e_col;
  logic        e_restart;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_age = 1; m_lock = 2'b00; m_col = '0;
      e_grant = 2'b00; e_col = '0; e_restart = 1'b0;
    end else begin
      m_elig    = req & ~m_lock;
      m_timeout = 1'b0;
      e_restart = 1'b0;
      if (m_phase == 0) begin
        if (m_elig != 2'b00) begin
          m_phase = 1; m_owner = m_elig[0] ? 0 : 1; m_age = 1;
        end else m_age++;
      end else if (m_phase == 1) begin
        if (m_age >= MAX) begin
          m_timeout = 1'b1; m_phase = 2; m_age = 1;
        end else if (m_age >= HOLD && (!req[m_owner] || (m_owner == 1 && m_elig[0]))) begin
          m_phase = 2; m_age = 1;
        end else m_age++;
      end else begin
        if (m_age >= GAP) begin
          if (m_elig != 2'b00) begin
            m_phase = 1; m_owner = m_elig[0] ? 0 : 1; m_age = 1;
          end else begin
            m_phase = 0; m_age = 1; e_restart = 1'b1;
          end
        end else m_age++;
      end
      for (int i = 0; i < 2; i++) begin
        if (!req[i]) m_lock[i] = 1'b0;
        else if (m_timeout && m_owner == i) m_lock[i] = 1'b1;
      end
      if (m_phase == 1 && req[m_owner]) m_col = (m_owner == 1) ? rgb1 : rgb0;
      e_grant = (m_phase == 1) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_col   = (m_phase == 0) ? {bg_red, bg_green, bg_blue} : (m_phase == 1) ? m_col : 45'd0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      n_total++;
      if ({grant, red, green, blue, bg_restart} === {e_grant, e_col, e_restart}) n_pass++;
      else $display("FAIL model t=%0t grant=%b rgb=%h restart=%b required grant=%b rgb=%h restart=%b",
                    $time, grant, {red, green, blue}, bg_restart, e_grant, e_col, e_restart);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    req = 2'b00; rgb0 = '0; rgb1 = '0;
    bg_red = 15'd100; bg_green = 15'd200; bg_blue = 15'd300;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cmp_on = 1'b1;

    // 1: reset values, then background passes through
    @(negedge clk);
    chk("rst_grant", grant, 0); chk("rst_red", red, 0); chk("rst_restart", bg_restart, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_red", red, 100); chk("t1_green", green, 200); chk("t1_blue", blue, 300);
    chk("t1_grant", grant, 0); chk("t1_restart", bg_restart, 0);
    nclk(3);
    chk("t1_restart_idle", bg_restart, 0);

    // 2: requester 0 owns for 10 cycles, then gap and background
    rgb0 = {15'h7FFF, 15'h0, 15'h0}; req = 2'b01;
    @(negedge clk);
    chk("t2_grant", grant, 2'b01); chk("t2_red", red, 15'h7FFF);
    nclk(9);
    chk("t2_grant_held", grant, 2'b01);
    req = 2'b00;
    @(negedge clk); chk("t2_gap1_grant", grant, 0); chk("t2_gap1_red", red, 0);
    @(negedge clk); chk("t2_gap2_red", red, 0);
    @(negedge clk); chk("t2_bg_restart", bg_restart, 1); chk("t2_bg_red", red, 100);
    @(negedge clk); chk("t2_restart_once", bg_restart, 0);

    // 3: short request 1 keeps hold time with frozen colour
    nclk(2);
    rgb1 = {15'h0, 15'h1111, 15'h0}; req = 2'b10;
    @(negedge clk); chk("t3_grant", grant, 2'b10); chk("t3_green1", green, 15'h1111);
    rgb1 = {15'h0, 15'h2222, 15'h0};
    @(negedge clk); chk("t3_green2", green, 15'h2222);
    req = 2'b00; rgb1 = {15'h0, 15'h3333, 15'h0};
    @(negedge clk); chk("t3_frozen", green, 15'h2222); chk("t3_grant3", grant, 2'b10);
    @(negedge clk); chk("t3_grant4", grant, 2'b10); chk("t3_frozen4", green, 15'h2222);
    @(negedge clk); chk("t3_gap_grant", grant, 0); chk("t3_gap_green", green, 0);
    @(negedge clk); chk("t3_gap2_green", green, 0);
    @(negedge clk); chk("t3_restart", bg_restart, 1);

    // 4: preemption of requester 1 by requester 0 after hold
    nclk(2);
    rgb0 = {15'h0, 15'h0, 15'h0AAA}; rgb1 = {15'h0555, 15'h0, 15'h0}; req = 2'b10;
    @(negedge clk); chk("t4_grant1", grant, 2'b10);
    @(negedge clk); req = 2'b11;
    @(negedge clk); chk("t4_held_c2", grant, 2'b10);
    @(negedge clk); chk("t4_held_c3", grant, 2'b10);
    @(negedge clk); chk("t4_gap1", grant, 0);
    @(negedge clk); chk("t4_gap2_red", red, 0);
    @(negedge clk); chk("t4_grant0", grant, 2'b01); chk("t4_blue", blue, 15'h0AAA);
    chk("t4_no_restart", bg_restart, 0);
    req = 2'b00;
    nclk(8);

    // 5: timeout, lock, regrant after req drop
    rgb0 = {15'h0123, 15'h0456, 15'h0789}; req = 2'b01;
    nclk(20);
    chk("t5_last_owned", grant, 2'b01);
    @(negedge clk); chk("t5_timeout_gap", grant, 0);
    @(negedge clk);
    @(negedge clk); chk("t5_restart", bg_restart, 1); chk("t5_bg_grant", grant, 0);
    @(negedge clk); chk("t5_locked", grant, 0);
    req = 2'b00;
    @(negedge clk); req = 2'b01;
    @(negedge clk); chk("t5_regrant", grant, 2'b01); chk("t5_red", red, 15'h0123);

    // 6: asynchronous reset mid-grant
    nclk(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_grant", grant, 0); chk("t6_red", red, 0); chk("t6_green", green, 0); chk("t6_blue", blue, 0);
    req = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("t6_bg_red", red, 100); chk("t6_bg_grant", grant, 0); chk("t6_restart", bg_restart, 0);

    // Random traffic against the model
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
      rgb0 = {13'($urandom()), 32'($urandom())};
      rgb1 = {13'($urandom()), 32'($urandom())};
      if ($urandom_range(0, 3) == 0) begin
        bg_red = 15'($urandom()); bg_green = 15'($urandom()); bg_blue = 15'($urandom());
      end
    end
    @(negedge clk);
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/led_color_arbiter.md
Name: led_color_arbiter

Overview:
- Shares the board RGB LED between the background colour-cycle pattern and two higher-priority requesters (button flash, host override).
- Sits between the pattern generator and the per-channel PWM drivers.
- Enforces minimum dwell, maximum ownership with lockout, and a blank gap between owners.
- Restarts the background pattern whenever the background regains the LED.

Parameters:
HOLD_TICKS, 100_000, minimum cycles a requester owns the LED before release or preemption.
MAX_TICKS, 50_000_000, maximum cycles of ownership before forced release; must be > HOLD_TICKS.
GAP_TICKS, 25_000, cycles of black (all channels 0) inserted between owners; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
bg_red  in  15  background red level
bg_green  in  15  background green level
bg_blue  in  15  background blue level
req  in  2  request lines; bit 0 = highest priority
rgb0  in  45  requester 0 colour {red[14:0], green[14:0], blue[14:0]}
rgb1  in  45  requester 1 colour, same packing as rgb0
grant  out  2  one-hot owner (registered); 0 = background or gap
red  out  15  registered red level to PWM
green  out  15  registered green level to PWM
blue  out  15  registered blue level to PWM
bg_restart  out  1  single-cycle pulse on return to background (drives the pattern generator's reset)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state S_BG, cnt 0, grant 0, red/green/blue 0, bg_restart 0, lock 2'b00.
  - No bg_restart pulse on reset release.
  - Reset mid-grant drops ownership immediately.
- cnt: 32-bit, cleared on every state entry, incremented each cycle otherwise.
- Eligibility: requester i is eligible when req[i] is high and lock[i] is 0. Winner = lowest-index eligible requester.
- lock[i]:
  - Set on forced (MAX_TICKS) release of requester i.
  - Cleared in any cycle where req[i] is low.
- Colour outputs: updated every cycle from the state-selected source, giving one cycle of latency.
  - S_BG: bg_*.
  - S_GRANT: latched owner colour.
  - S_GAP: 0.
- Owner colour latch: copies rgbN every cycle while req[owner] is high; holds its last value while req[owner] is low.
- State S_BG:
  - grant = 0.
  - Any eligible requester → S_GRANT with owner = winner. grant becomes one-hot in the next cycle, i.e. one cycle after req is sampled.
- State S_GRANT:
  - Release: cnt >= HOLD_TICKS-1 and req[owner] low → S_GAP.
  - Preemption: cnt >= HOLD_TICKS-1 and a higher-priority eligible requester exists → S_GAP.
  - Timeout: cnt >= MAX_TICKS-1 → S_GAP and lock[owner] set. Timeout takes precedence over release and preemption in the same cycle.
  - A requester dropping req before HOLD_TICKS keeps ownership until the hold time expires, showing the frozen colour.
  - A lower-priority request never preempts.
- State S_GAP:
  - grant = 0, outputs black.
  - At cnt >= GAP_TICKS-1: any eligible requester → S_GRANT (winner); otherwise → S_BG and bg_restart = 1 for exactly that transition cycle.
  - Requests arriving or leaving during the gap are only evaluated at gap end.
- Illegal state encoding → S_BG, grant 0, outputs 0.
- Simultaneous requests: req = 2'b11 from S_BG grants requester 0.
- Timed-out owner while the other requester is idle: gap, then background with a bg_restart pulse.
- Expected size: 150–250 lines RTL.

Test Plan:
(Bench parameters: HOLD_TICKS=4, MAX_TICKS=20, GAP_TICKS=2.)
1. Reset then idle, bg_* = {100,200,300} → one cycle later red/green/blue = 100/200/300, grant = 0, bg_restart never pulses.
2. req = 01 for 10 cycles with rgb0 = {7FFF,0,0}, then drop:
   - grant = 01 one cycle after req rises, red = 0x7FFF.
   - 2 black cycles after release.
   - Then background restored with one bg_restart pulse.
3. req[1] held for 2 cycles only → grant = 10 for 4 cycles showing the frozen rgb1, then gap, then background.
4. req[1] owning, req[0] rises at cnt = 1 → ownership held until cnt = 3, then 2-cycle gap, then grant = 01, with no bg_restart.
5. req[0] held continuously → forced release after 20 cycles; lock keeps the gap going to background (bg_restart pulse); dropping req[0] one cycle then raising it → regranted.
6. Assert rst_n low mid-grant asynchronously → grant/red/green/blue = 0 without waiting for clk; state S_BG after release.
